// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional HI/LO write-back fields are enabled by defining HILO_EN.
module ex_mem_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NOP_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
`ifdef HILO_EN
    input  logic              ex_whilo,
    input  logic [DATA_W-1:0] ex_hi,
    input  logic [DATA_W-1:0] ex_lo,
    output logic              mem_whilo,
    output logic [DATA_W-1:0] mem_hi,
    output logic [DATA_W-1:0] mem_lo,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wreg,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef struct packed {
        logic              wreg;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
`ifdef HILO_EN
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
`endif
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t  state_q, state_nxt;
    bundle_t main_q, main_nxt;
    bundle_t skid_q, skid_nxt;
    bundle_t ex_b, nop_b;
    logic    valid_nxt;
    logic    ready_nxt;
    logic    accept;
    logic    xfer;

    // Next-state and payload steering; flush overrides everything.
    always_comb begin
        ex_b       = '0;
        ex_b.wreg  = ex_wreg;
        ex_b.waddr = ex_waddr;
        ex_b.wdata = ex_wdata;
`ifdef HILO_EN
        ex_b.whilo = ex_whilo;
        ex_b.hi    = ex_hi;
        ex_b.lo    = ex_lo;
`endif
        nop_b       = '0;
        nop_b.waddr = ADDR_W'(NOP_ADDR);

        accept    = ex_valid & ex_ready;
        xfer      = mem_valid & mem_ready;
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        valid_nxt = mem_valid;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_nxt  = ex_b;
                    valid_nxt = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (xfer && accept) begin
                    main_nxt = ex_b;
                end else if (xfer) begin
                    // Bubble: enables drop, address/data keep their last value.
                    main_nxt.wreg = 1'b0;
`ifdef HILO_EN
                    main_nxt.whilo = 1'b0;
`endif
                    valid_nxt = 1'b0;
                    state_nxt = S_EMPTY;
                end else if (accept) begin
                    skid_nxt  = ex_b;
                    state_nxt = S_TWO;
                end
            end
            S_TWO: begin
                if (xfer) begin
                    main_nxt  = skid_q;
                    skid_nxt  = nop_b;
                    state_nxt = S_ONE;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
                valid_nxt = 1'b0;
            end
        endcase

        if (flush) begin
            state_nxt = S_EMPTY;
            main_nxt  = nop_b;
            skid_nxt  = nop_b;
            valid_nxt = 1'b0;
        end

        ready_nxt = (state_nxt != S_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            main_q        <= '0;
            main_q.waddr  <= ADDR_W'(NOP_ADDR);
            skid_q        <= '0;
            skid_q.waddr  <= ADDR_W'(NOP_ADDR);
            mem_valid     <= 1'b0;
            ex_ready      <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            main_q    <= main_nxt;
            skid_q    <= skid_nxt;
            mem_valid <= valid_nxt;
            ex_ready  <= ready_nxt;
        end
    end

    // main_q.wreg is cleared whenever main empties, so it already equals wreg & valid.
    assign mem_wreg  = main_q.wreg;
    assign mem_waddr = main_q.waddr;
    assign mem_wdata = main_q.wdata;
`ifdef HILO_EN
    assign mem_whilo = main_q.whilo;
    assign mem_hi    = main_q.hi;
    assign mem_lo    = main_q.lo;
`endif

endmodule
